gate_unit_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one bitwise logic unit between N_REQ requesters.
- The unit is built from 2:1 muxes and supports AND, OR, NAND, NOR, XOR and XNOR.
- Each requester submits op/a/b with a valid/ready handshake. The block grants one requester, evaluates the operation, and returns the result with the requester ID over a valid/ready response channel.
- Sits between multiple client blocks and the mux-based gate datapath; the only path into that datapath.

---
 rtl/gate_unit_arbiter.sv | 169 ++++++++++++++++
 tb/tb_gate_unit_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gate_unit_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one mux-based bitwise
//            logic unit (AND/OR/NAND/NOR/XOR/XNOR) between N_REQ requesters.
//            Responses carry the owning requester ID over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module gate_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [3*N_REQ-1:0] req_op,
  input  logic [W*N_REQ-1:0] req_a,
  input  logic [W*N_REQ-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [W-1:0]       rsp_data,
  output logic               rsp_err,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  logic [2:0]     op_q;
  logic [W-1:0]   a_q, b_q;
  logic [IDW-1:0] idx_q;

  logic           rsp_valid_q, rsp_err_q;
  logic [IDW-1:0] rsp_id_q;
  logic [W-1:0]   rsp_data_q;

  logic             any_valid;
  logic [IDW-1:0]   gnt_idx;
  logic [N_REQ-1:0] gnt_oh;
  logic [2:0]       w_op;
  logic [W-1:0]     w_a, w_b;

  logic [W-1:0]     w_in1, w_in0, w_res;
  logic             w_illegal;

  assign any_valid = |req_valid;

  // Round-robin search: nearest valid requester after rr_ptr wins (smallest offset assigned last).
  always_comb begin : p_grant
    int               j;
    logic [N_REQ-1:0] rot;
    j       = 0;
    rot     = '0;
    gnt_idx = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      j   = (int'(rr_ptr_q) + off) % N_REQ;
      rot = req_valid >> j;
      if (rot[0]) gnt_idx = IDW'(j);
    end
  end

  // Extract the granted requester's payload via shifts so no variable part-selects are needed.
  always_comb begin
    w_op   = 3'(req_op >> (3 * int'(gnt_idx)));
    w_a    = W'(req_a >> (W * int'(gnt_idx)));
    w_b    = W'(req_b >> (W * int'(gnt_idx)));
    gnt_oh = any_valid ? (N_REQ'(1) << gnt_idx) : '0;
  end

  // Grant is only offered while idle; forced low while reset is asserted.
  assign req_ready = (state_q == IDLE && !rst) ? gnt_oh : '0;

  // Mux input pair per op: result bit = a[k] ? in1[k] : in0[k].
  always_comb begin
    w_in1     = '0;
    w_in0     = '0;
    w_illegal = 1'b0;
    case (op_q)
      3'd0:    begin w_in1 = b_q;  w_in0 = '0;   end
      3'd1:    begin w_in1 = '1;   w_in0 = b_q;  end
      3'd2:    begin w_in1 = ~b_q; w_in0 = '1;   end
      3'd3:    begin w_in1 = '0;   w_in0 = ~b_q; end
      3'd4:    begin w_in1 = ~b_q; w_in0 = b_q;  end
      3'd5:    begin w_in1 = b_q;  w_in0 = ~b_q; end
      default: w_illegal = 1'b1;
    endcase
  end

  genvar k;
  generate
    for (k = 0; k < W; k++) begin : g_bit
      assign w_res[k] = a_q[k] ? w_in1[k] : w_in0[k];
    end
  endgenerate

  // Next-state logic: IDLE -> EXEC on grant, EXEC -> RESP, RESP -> IDLE on handshake.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d  = EXEC;
          rr_ptr_d = gnt_idx;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and round-robin pointer; pointer resets to N_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= IDW'(N_REQ - 1);
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Capture request on grant, evaluate in EXEC, hold response until handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      if (state_q == IDLE && any_valid) begin
        op_q  <= w_op;
        a_q   <= w_a;
        b_q   <= w_b;
        idx_q <= gnt_idx;
      end
      if (state_q == EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= w_illegal ? '0 : w_res;
        rsp_err_q   <= w_illegal;
        rsp_id_q    <= idx_q;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gate_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_unit_arbiter
// Brief    : Self-checking bench for gate_unit_arbiter: vector table of
//            single-requester ops plus directed arbitration/stall/reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_unit_arbiter;

  localparam int N_REQ = 4;
  localparam int W     = 8;
  localparam int IDW   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [3*N_REQ-1:0] req_op;
  logic [W*N_REQ-1:0] req_a;
  logic [W*N_REQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [W-1:0]       rsp_data;
  logic               rsp_err;
  logic               busy;

  int checks = 0;
  int errors = 0;

  gate_unit_arbiter #(.N_REQ(N_REQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         rid;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[3*r +: 3] = op;
    req_a[8*r +: 8]  = a;
    req_b[8*r +: 8]  = b;
  endtask

  function automatic int oh2i(input logic [N_REQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N_REQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // One single-requester transaction with response ready held high.
  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    set_req(v.rid, v.op, v.a, v.b);
    req_valid = N_REQ'(1) << v.rid;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("vec_grant", req_ready, 32'(1) << v.rid);
    chk("vec_idle_busy", busy, 0);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("vec_exec_ready", req_ready, 0);
    chk("vec_exec_valid", rsp_valid, 0);
    chk("vec_exec_busy", busy, 1);
    @(negedge clk);
    chk("vec_rsp_valid", rsp_valid, 1);
    chk("vec_rsp_id", rsp_id, v.rid);
    chk("vec_rsp_data", rsp_data, v.exp_data);
    chk("vec_rsp_err", rsp_err, v.exp_err);
    @(negedge clk);
    chk("vec_done_valid", rsp_valid, 0);
    chk("vec_done_busy", busy, 0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int gi[5], gc[5], ri[5], rd[5];
    int n, m;
    int exp_g[5] = '{0, 1, 2, 3, 0};

    vecs[0] = '{1, 3'd4, 8'hF0, 8'hAA, 8'h5A, 1'b0};
    vecs[1] = '{2, 3'd0, 8'hCC, 8'hAA, 8'h88, 1'b0};
    vecs[2] = '{2, 3'd1, 8'hCC, 8'hAA, 8'hEE, 1'b0};
    vecs[3] = '{2, 3'd2, 8'hCC, 8'hAA, 8'h77, 1'b0};
    vecs[4] = '{2, 3'd3, 8'hCC, 8'hAA, 8'h11, 1'b0};
    vecs[5] = '{2, 3'd4, 8'hCC, 8'hAA, 8'h66, 1'b0};
    vecs[6] = '{2, 3'd5, 8'hCC, 8'hAA, 8'h99, 1'b0};
    vecs[7] = '{0, 3'd5, 8'h0F, 8'h0F, 8'hFF, 1'b0};
    vecs[8] = '{2, 3'd6, 8'hCC, 8'hAA, 8'h00, 1'b1};
    vecs[9] = '{2, 3'd7, 8'hCC, 8'hAA, 8'h00, 1'b1};

    // Reset state, with all requesters valid while reset is held.
    rst       = 1'b1;
    req_valid = '1;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = '0;

    // All requesters held valid: grant order 0,1,2,3,0, one grant per 3 cycles.
    for (int i = 0; i < N_REQ; i++) set_req(i, 3'd0, 8'hFF, 8'(8'h10 + i));
    rsp_ready = 1'b1;
    req_valid = '1;
    n = 0;
    m = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (req_ready != 0 && n < 5) begin
        gi[n] = oh2i(req_ready);
        gc[n] = cyc;
        n++;
      end
      if (rsp_valid && rsp_ready && m < 5) begin
        ri[m] = int'(rsp_id);
        rd[m] = int'(rsp_data);
        m++;
      end
      @(posedge clk); #1;
      if (n == 5) req_valid = '0;
    end
    chk("rr_grant_count", n, 5);
    chk("rr_rsp_count", m, 5);
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant_order", gi[i], exp_g[i]);
      chk("rr_rsp_id", ri[i], exp_g[i]);
      chk("rr_rsp_data", rd[i], 32'h10 + exp_g[i]);
      if (i > 0) chk("rr_grant_spacing", gc[i] - gc[i-1], 3);
    end

    // Vector table: single requester, every op code.
    for (int v = 0; v < 10; v++) run_vec(vecs[v]);

    // Stall in RESP: last grant was 2; requesters 0 and 3 valid -> 3 granted next.
    @(posedge clk); #1;
    set_req(3, 3'd4, 8'h3C, 8'h00);
    set_req(0, 3'd1, 8'h00, 8'h55);
    rsp_ready = 1'b0;
    req_valid = 4'b1001;
    @(negedge clk);
    chk("stall_grant3", req_ready, 4'b1000);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("stall_exec_ready", req_ready, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_id", rsp_id, 3);
      chk("stall_data", rsp_data, 8'h3C);
      chk("stall_ready0", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_hs_valid", rsp_valid, 1);
    @(negedge clk);
    chk("wrap_grant0", req_ready, 4'b0001);
    chk("wrap_rsp_valid", rsp_valid, 0);
    chk("wrap_busy", busy, 0);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("wrap_rsp_valid1", rsp_valid, 1);
    chk("wrap_rsp_id", rsp_id, 0);
    chk("wrap_rsp_data", rsp_data, 8'h55);
    @(negedge clk);
    chk("wrap_done", busy, 0);

    // Reset while a response (0x3C) is pending in RESP.
    @(posedge clk); #1;
    set_req(1, 3'd0, 8'h3C, 8'hFF);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", rsp_valid, 1);
    chk("pre_rst_data", rsp_data, 8'h3C);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", rsp_valid, 0);
    chk("async_rst_data", rsp_data, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_id", rsp_id, 0);
    req_valid = '1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_prio", req_ready, 4'b0001);
    req_valid = '0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
